// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg : shared depth constant and Gray/binary pointer conversions
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int unsigned FIFO_ADDRSIZE = 4;
  localparam int unsigned DEPTH         = 1 << FIFO_ADDRSIZE;

  // 32-bit wide so any pointer width up to 32 can use them via size casts.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_w2r.sv
// ----------------------------------------------------------------------------
// sync_w2r : two-flop synchronizer bringing the Gray write pointer into rclk
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_w2r #(
  parameter int WIDTH = 5
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [WIDTH-1:0] wptr_i,
  output logic [WIDTH-1:0] rq2_wptr_o
);

  logic [WIDTH-1:0] rq1_q;
  logic [WIDTH-1:0] rq2_q;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= wptr_i;
      rq2_q <= rq1_q;
    end
  end

  assign rq2_wptr_o = rq2_q;

endmodule

`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_read_ctrl : async FIFO read side with FWFT output register and level
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  input  logic                rready,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0]       rq2_wptr;
  logic [PW-1:0]       rbin_q,   rbin_d;
  logic [PW-1:0]       rptr_q,   rgray_d;
  logic [PW-1:0]       rlevel_q, rlevel_d;
  logic [DATASIZE-1:0] rdata_q,  rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rempty_q, rempty_d;
  logic                fetch;
  logic                consume;

  sync_w2r #(
    .WIDTH (PW)
  ) u_sync_w2r (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .wptr_i     (wptr),
    .rq2_wptr_o (rq2_wptr)
  );

  // Output register refills in the same cycle it drains, giving 1 word/cycle.
  assign consume = rvalid_q & rready;
  assign fetch   = ~rempty_q & (~rvalid_q | rready);

  always_comb begin
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
    rgray_d  = PW'(bin2gray(32'(rbin_d)));
    rempty_d = (rgray_d == rq2_wptr);
    rlevel_d = PW'(gray2bin(32'(rq2_wptr))) - rbin_d;
    rdata_d  = fetch ? mem_rdata : rdata_q;
    if (fetch) begin
      rvalid_d = 1'b1;
    end else if (consume) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      rempty_q <= rempty_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rlevel_q <= rlevel_d;
    end
  end

  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rptr   = rptr_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rempty = rempty_q;
  assign rlevel = rlevel_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_read_ctrl : directed + random bench with a word-count reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_read_ctrl;

  logic       rclk;
  logic       rrst_n;
  logic [4:0] wptr;
  logic [7:0] mem_rdata;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       rempty;
  logic [4:0] rlevel;

  logic [7:0] mem [16];

  int checks   = 0;
  int failures = 0;

  // Reference model state: absolute word counts, not pointers.
  int         wcount;
  int         m_f, m_c, s1, s2, m_level;
  bit         m_valid, m_empty;
  logic [7:0] m_data;
  logic [7:0] wlog [$];
  logic [7:0] expq [$];
  logic [4:0] prev_rptr;
  bit         was_reset;

  fifo_read_ctrl #(
    .DATASIZE (8),
    .ADDRSIZE (4)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .wptr      (wptr),
    .mem_rdata (mem_rdata),
    .raddr     (raddr),
    .rptr      (rptr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .rempty    (rempty),
    .rlevel    (rlevel)
  );

  assign mem_rdata = mem[raddr];

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wcount % 16] = d;
    wlog.push_back(d);
    expq.push_back(d);
    wcount++;
    wptr = gray5(wcount);
  endtask

  function automatic bit has_space();
    return (wcount - m_c) < 16;
  endfunction

  task automatic clear_write_side();
    wcount = 0;
    wptr   = 5'd0;
    wlog.delete();
    expq.delete();
  endtask

  // One rclk edge: advance the model from pre-edge inputs, then compare.
  task automatic step();
    bit fetch, cons;
    if (rrst_n && rvalid && rready) begin
      chk("stream_nonempty", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) chk("stream_data", 32'(rdata), 32'(expq.pop_front()));
    end
    was_reset = !rrst_n;
    if (!rrst_n) begin
      m_f = 0; m_c = 0; s1 = 0; s2 = 0; m_level = 0;
      m_valid = 0; m_empty = 1; m_data = 8'h00;
    end else begin
      fetch = !m_empty && (!m_valid || rready);
      cons  = m_valid && rready;
      if (cons) m_c++;
      if (fetch) begin
        m_data = wlog[m_f];
        m_f++;
      end
      m_valid = fetch ? 1'b1 : (cons ? 1'b0 : m_valid);
      m_empty = (m_f == s2);
      m_level = s2 - m_f;
      s2 = s1;
      s1 = wcount;
    end
    prev_rptr = rptr;
    @(posedge rclk);
    #1;
    chk("rvalid", 32'(rvalid), 32'(m_valid));
    chk("rempty", 32'(rempty), 32'(m_empty));
    chk("rlevel", 32'(rlevel), 32'(m_level % 32));
    chk("rdata",  32'(rdata),  32'(m_data));
    chk("rptr",   32'(rptr),   32'(gray5(m_f)));
    chk("raddr",  32'(raddr),  32'(m_f % 16));
    if (!was_reset) chk("gray_1bit", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
  endtask

  task automatic do_reset(input int n);
    rrst_n = 1'b0;
    rready = 1'b0;
    clear_write_side();
    repeat (n) step();
    rrst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n = 0;
    while (!rvalid && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(rvalid), 32'd1);
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    rready = 1'b1;
    while ((expq.size() != 0) && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int w5;
    int n;
    rrst_n = 1'b0;
    rready = 1'b0;
    wptr   = 5'd0;
    wcount = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_f = 0; m_c = 0; s1 = 0; s2 = 0; m_level = 0;
    m_valid = 0; m_empty = 1; m_data = 8'h00;
    #2;

    // 1. reset
    do_reset(2);
    chk("t1_rempty", 32'(rempty), 32'd1);
    chk("t1_rvalid", 32'(rvalid), 32'd0);
    chk("t1_rlevel", 32'(rlevel), 32'd0);

    // 2. single word, then one consume
    write_word(8'hA5);
    repeat (3) step();
    chk("t2_rempty_fell", 32'(rempty), 32'd0);
    chk("t2_rvalid_early", 32'(rvalid), 32'd0);
    step();
    chk("t2_rvalid", 32'(rvalid), 32'd1);
    chk("t2_rdata", 32'(rdata), 32'hA5);
    chk("t2_raddr", 32'(raddr), 32'd1);
    chk("t2_rptr", 32'(rptr), 32'd1);
    rready = 1'b1;
    step();
    chk("t2_rvalid_after", 32'(rvalid), 32'd0);
    chk("t2_rempty_after", 32'(rempty), 32'd1);
    rready = 1'b0;

    // 3. backpressure
    do_reset(1);
    write_word(8'hB0); write_word(8'hB1); write_word(8'hB2);
    repeat (8) step();
    chk("t3_rvalid", 32'(rvalid), 32'd1);
    chk("t3_rdata", 32'(rdata), 32'hB0);
    chk("t3_rlevel", 32'(rlevel), 32'd2);
    chk("t3_rptr", 32'(rptr), 32'd1);
    drain("t3_drain", 20);
    rready = 1'b0;

    // 4. full 16-word stream with no bubbles
    do_reset(1);
    for (int i = 0; i < 16; i++) write_word(8'(i));
    rready = 1'b1;
    wait_valid("t4_first_valid", 10);
    for (int i = 0; i < 16; i++) begin
      chk("t4_nobubble", 32'(rvalid), 32'd1);
      step();
    end
    chk("t4_rptr_end", 32'(rptr), 32'b11000);
    chk("t4_rempty_end", 32'(rempty), 32'd1);
    chk("t4_all_out", 32'(expq.size()), 32'd0);

    // 5. random bursts and random rready across pointer wrap
    w5 = 0;
    n  = 0;
    while ((w5 < 40 || expq.size() != 0) && n < 3000) begin
      if (w5 < 40 && ($urandom % 3) == 0) begin
        int burst;
        burst = $urandom_range(1, 4);
        for (int j = 0; j < burst; j++) begin
          if (w5 < 40 && has_space()) begin
            write_word(8'($urandom));
            w5++;
          end
        end
      end
      rready = 1'($urandom % 2);
      step();
      n++;
    end
    rready = 1'b1;
    repeat (2) step();
    chk("t5_written", 32'(w5), 32'd40);
    chk("t5_drained", 32'(expq.size()), 32'd0);
    chk("t5_rptr_end", 32'(rptr), 32'(gray5(56)));
    chk("t5_rvalid_end", 32'(rvalid), 32'd0);

    // 6. reset mid-stream with a held word and level 5
    do_reset(1);
    for (int i = 0; i < 6; i++) write_word(8'(8'hC0 + i));
    repeat (8) step();
    chk("t6_pre_rvalid", 32'(rvalid), 32'd1);
    chk("t6_pre_rlevel", 32'(rlevel), 32'd5);
    rrst_n = 1'b0;
    rready = 1'b1;
    clear_write_side();
    step();
    chk("t6_rvalid", 32'(rvalid), 32'd0);
    chk("t6_rdata", 32'(rdata), 32'd0);
    chk("t6_rempty", 32'(rempty), 32'd1);
    chk("t6_rlevel", 32'(rlevel), 32'd0);
    chk("t6_rptr", 32'(rptr), 32'd0);
    chk("t6_raddr", 32'(raddr), 32'd0);
    rrst_n = 1'b1;
    repeat (4) step();
    chk("t6_idle_rvalid", 32'(rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
